// File: rtl/basys3_keypad_pkg.sv
// basys3_keypad_pkg: scanner states, key map and column drive constants shared by the keypad scanner.
package basys3_keypad_pkg;

   typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_e;

   // Hex code indexed as KEYMAP[column][row]
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'h1, 4'h4, 4'h7, 4'h0},
      '{4'h2, 4'h5, 4'h8, 4'hF},
      '{4'h3, 4'h6, 4'h9, 4'hE},
      '{4'hA, 4'hB, 4'hC, 4'hD}
   };

   localparam logic [3:0] COL_ONECOLD [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // Index of the lowest active-low row; only meaningful when some row is low
   function automatic logic [1:0] lowest_low(input logic [3:0] rows);
      return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
   endfunction

endpackage

// File: rtl/basys3_sync2.sv
// basys3_sync2: 4-bit two-flop synchroniser, idles at 4'b1111 (no row pulled low).
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronised output
module basys3_sync2 (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] d_i,
   output logic [3:0] q_o
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 4'hF;
         sync_q <= 4'hF;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/basys3_keypad_scanner.sv
// basys3_keypad_scanner: column-multiplexed 4x4 keypad scanner with press/release debounce.
//   clk_1k_i    : 1 kHz scan clock
//   rst_ni      : asynchronous active-low reset
//   row_i       : keypad rows, active-low, asynchronous
//   col_o       : one-cold active-low column drive
//   key_o       : hex code of the last accepted key
//   key_valid_o : one-cycle strobe on an accepted press
//   key_held_o  : high from press acceptance until release acceptance
module basys3_keypad_scanner import basys3_keypad_pkg::*; #(
   parameter int SETTLE_CYCLES   = 3,
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic       clk_1k_i,
   input  logic       rst_ni,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   output logic [3:0] key_o,
   output logic       key_valid_o,
   output logic       key_held_o
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES > DEBOUNCE_CYCLES ? SETTLE_CYCLES : DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       rows;
   state_e           state_q, state_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic [3:0]       key_q, key_d;
   logic             key_valid_q, key_valid_d;
   logic             key_held_q, key_held_d;
   logic             settle_done, db_done, row_low;

   basys3_sync2 u_sync (
      .clk_i  (clk_1k_i),
      .rst_ni (rst_ni),
      .d_i    (row_i),
      .q_o    (rows)
   );

   assign settle_done = settle_cnt_q == SETTLE_LAST;
   assign db_done     = db_cnt_q == DB_LAST;
   assign row_low     = !rows[row_idx_q];

   always_ff @(posedge clk_1k_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= SCAN;
         col_idx_q    <= '0;
         row_idx_q    <= '0;
         settle_cnt_q <= '0;
         db_cnt_q     <= '0;
         key_q        <= '0;
         key_valid_q  <= 1'b0;
         key_held_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_idx_q    <= col_idx_d;
         row_idx_q    <= row_idx_d;
         settle_cnt_q <= settle_cnt_d;
         db_cnt_q     <= db_cnt_d;
         key_q        <= key_d;
         key_valid_q  <= key_valid_d;
         key_held_q   <= key_held_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SCAN:       if (settle_done && rows != 4'hF) state_d = PRESS_DB;
         PRESS_DB:   state_d = !row_low ? SCAN : db_done ? HELD : PRESS_DB;
         HELD:       if (!row_low) state_d = RELEASE_DB;
         RELEASE_DB: state_d = row_low ? HELD : db_done ? SCAN : RELEASE_DB;
         default:    state_d = SCAN;
      endcase
   end

   // Counters fall back to zero whenever a state does not advance them,
   // so every state entry starts its count afresh.
   always_comb begin
      col_idx_d    = col_idx_q;
      row_idx_d    = row_idx_q;
      settle_cnt_d = '0;
      db_cnt_d     = '0;
      key_d        = key_q;
      key_valid_d  = 1'b0;
      key_held_d   = key_held_q;
      case (state_q)
         SCAN: begin
            settle_cnt_d = settle_done ? '0 : settle_cnt_q + 1'b1;
            if (settle_done && rows == 4'hF) col_idx_d = col_idx_q + 2'd1;
            if (settle_done && rows != 4'hF) row_idx_d = lowest_low(rows);
         end
         PRESS_DB: begin
            if (!row_low) col_idx_d = col_idx_q + 2'd1;
            else if (db_done) begin
               key_d       = KEYMAP[col_idx_q][row_idx_q];
               key_valid_d = 1'b1;
               key_held_d  = 1'b1;
            end else db_cnt_d = db_cnt_q + 1'b1;
         end
         RELEASE_DB: begin
            if (!row_low && db_done) begin
               key_held_d = 1'b0;
               col_idx_d  = col_idx_q + 2'd1;
            end else if (!row_low) db_cnt_d = db_cnt_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign col_o       = COL_ONECOLD[col_idx_q];
   assign key_o       = key_q;
   assign key_valid_o = key_valid_q;
   assign key_held_o  = key_held_q;

endmodule

// File: tb/tb_basys3_keypad_scanner.sv
// tb_basys3_keypad_scanner: directed keypad stimulus with a scoreboard checking every key strobe.
module tb_basys3_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row_i;
   logic [3:0]  col_o;
   logic [3:0]  key_o;
   logic        key_valid_o;
   logic        key_held_o;
   logic [15:0] pressed = '0;
   logic [3:0]  exp_q[$];
   logic [3:0]  idle_exp [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
   int          total = 0;
   int          bad = 0;

   basys3_keypad_scanner dut (
      .clk_1k_i    (clk),
      .rst_ni      (rst_n),
      .row_i       (row_i),
      .col_o       (col_o),
      .key_o       (key_o),
      .key_valid_o (key_valid_o),
      .key_held_o  (key_held_o)
   );

   always #5 clk = ~clk;

   // Keypad model: pressed[c*4+r] shorts column c to row r
   always_comb begin
      row_i = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (pressed[c*4+r] && !col_o[c]) row_i[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (rst_n && key_valid_o) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: key_o=%h, no pulse expected", key_o);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (key_o !== e) begin
               bad++;
               $display("FAIL pulse_key: key_o=%h want %h", key_o, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic wait_col(input logic [3:0] v, input string name);
      int n = 0;
      @(negedge clk);
      while (col_o !== v && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (col_o !== v) check(name, col_o, v);
   endtask

   task automatic wait_held(input logic v, input string name);
      int n = 0;
      @(negedge clk);
      while (key_held_o !== v && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (key_held_o !== v) check(name, key_held_o, v);
   endtask

   initial begin
      int n;
      bit seen;
      #3;
      check("rst_col", col_o, 4'b1110);
      check("rst_key", key_o, 4'h0);
      check("rst_valid", key_valid_o, 1'b0);
      check("rst_held", key_held_o, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      wait_col(4'b1101, "idle_sync");
      for (int i = 0; i < 12; i++) begin
         check($sformatf("idle_col%0d", i), col_o, idle_exp[i/3]);
         @(negedge clk);
      end

      pressed[1*4+2] = 1'b1;
      exp_q.push_back(4'h8);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (key_valid_o) begin
            seen = 1;
            check("held_with_pulse", key_held_o, 1'b1);
         end
         if (key_held_o) check("col1_frozen", col_o, 4'b1101);
      end
      check("col1_pulse_seen", seen, 1'b1);
      pressed = '0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (key_held_o) check("col1_frozen_rel", col_o, 4'b1101);
      end while (key_held_o && n < 60);
      check("held_fall_cycles", n, 23);
      check("col_after_release", col_o, 4'b1011);
      check("key_retained", key_o, 4'h8);

      wait_col(4'b0111, "bounce_align3");
      wait_col(4'b1110, "bounce_align0");
      pressed[0] = 1'b1;
      repeat (5) @(negedge clk);
      pressed[0] = 1'b0;
      @(negedge clk);
      pressed[0] = 1'b1;
      @(negedge clk);
      check("bounce_col_frozen", col_o, 4'b1110);
      @(negedge clk);
      check("bounce_resume_col1", col_o, 4'b1101);
      repeat (3) @(negedge clk);
      pressed[0] = 1'b0;
      repeat (30) @(negedge clk);
      check("bounce_no_held", key_held_o, 1'b0);

      pressed[2*4+1] = 1'b1;
      pressed[2*4+3] = 1'b1;
      exp_q.push_back(4'h6);
      repeat (40) @(negedge clk);
      pressed = '0;
      wait_held(1'b0, "col2_release");

      wait_col(4'b1011, "col3_align2");
      wait_col(4'b0111, "col3_align3");
      pressed[3*4+0] = 1'b1;
      exp_q.push_back(4'hA);
      repeat (30) @(negedge clk);
      pressed = '0;
      repeat (30) @(negedge clk);
      pressed[3*4+0] = 1'b1;
      exp_q.push_back(4'hA);
      repeat (30) @(negedge clk);
      pressed = '0;
      wait_held(1'b0, "col3_release");

      pressed[0*4+1] = 1'b1;
      exp_q.push_back(4'h4);
      wait_held(1'b1, "rst_test_press");
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_col", col_o, 4'b1110);
      check("async_rst_key", key_o, 4'h0);
      check("async_rst_valid", key_valid_o, 1'b0);
      check("async_rst_held", key_held_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(4'h4);
      wait_held(1'b1, "rst_test_redetect");
      check("redetect_key", key_o, 4'h4);
      pressed = '0;
      wait_held(1'b0, "rst_test_release");
      repeat (5) @(negedge clk);

      check("pulses_outstanding", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
